mem_stage_ctrl: RTL and testbench
=================================

// Module: mem_stage_ctrl
// PURPOSE
//  Consumer side of the EX/MEM pipeline register in the 16-bit pipelined CPU.
//  - Holds EX/MEM by driving its wen low while a data-memory access is in flight.
//  - Runs a req/ack handshake with data memory.
//  - Resolves taken branches.
//  - Contains the MEM/WB pipeline register, which feeds write-back.
// PARAMETERS
//  DW        16   data/address width
//  RW        4    destination-register field width (muxout)
//  TO_CYCLES 255  REQ-state cycles before abort (only with MEM_TIMEOUT_EN)
// PORTS
//  clk           in   1   clock, rising edge
//  rst           in   1   synchronous, active-low reset
//  regwrite      in   1   EX/MEM regwrite_current
//  memtoreg      in   1   EX/MEM memtoreg_current
//  branch        in   1   EX/MEM branch_current
//  memwrite      in   1   EX/MEM memwrite_current
//  memread       in   1   EX/MEM memread_current
//  addresult     in   DW  EX/MEM branch target
//  aluresult     in   DW  EX/MEM ALU result / memory address
//  regread2      in   DW  EX/MEM store data
//  zeroflag      in   1   EX/MEM zero flag
//  muxout        in   RW  EX/MEM destination register
//  mem_ack       in   1   memory done; mem_rdata valid same cycle
//  mem_rdata     in   DW  memory read data
//  mem_req       out  1   access request
//  mem_we        out  1   1 = write
//  mem_addr      out  DW  = aluresult
//  mem_wdata     out  DW  = regread2
//  exmem_wen     out  1   drives EX/MEM wen (0 = hold)
//  pc_src        out  1   branch taken
//  branch_target out  DW  = addresult
//  wb_regwrite   out  1   MEM/WB regwrite
//  wb_memtoreg   out  1   MEM/WB memtoreg
//  wb_rdata      out  DW  MEM/WB load data
//  wb_alu        out  DW  MEM/WB ALU result
//  wb_dst        out  RW  MEM/WB destination register
//  mem_err       out  1   sticky timeout flag
// BEHAVIOUR
//  - Every cycle with exmem_wen=1 presents a new instruction; access = memread|memwrite.
//  - FSM:
//    IDLE: access=0 -> exmem_wen=1; MEM/WB loads at the edge (1-cycle latency).
//          access=1 -> exmem_wen=0; MEM/WB loads a bubble (wb_regwrite=0); next REQ.
//    REQ:  mem_req=1, exmem_wen=0; addr, wdata and we are stable (inputs are held).
//          mem_ack=1 -> capture mem_rdata into rdbuf; next DONE. Else stay in REQ.
//    DONE: mem_req=0, exmem_wen=1; MEM/WB loads the instruction with wb_rdata=rdbuf;
//          next IDLE. Access is not re-evaluated in DONE, so no double issue.
//  - Minimum access cost: 2 stall cycles (ack in the first REQ cycle).
//  - mem_we = memwrite. memread=memwrite=1 is treated as a write; rdbuf is still captured.
//  - mem_ack outside REQ is ignored.
//  - pc_src = branch & zeroflag & (state==IDLE), combinational.
//  - mem_req, mem_we and exmem_wen are combinational from state and inputs.
//  - Reset (rst=0 at an edge), including mid-REQ:
//    - state=IDLE.
//    - All MEM/WB outputs and rdbuf = 0; mem_err=0.
//    - mem_req drops in the cycle after the edge; an in-flight access is abandoned.
// CONFIGURATION
//  MEM_TIMEOUT_EN defined:
//    - An 8-bit counter clears on entry to REQ and increments each REQ cycle without ack.
//    - Reaching TO_CYCLES -> DONE; mem_err set (sticky until reset); that instruction
//      retires with wb_regwrite=0.
//    - Ack on the same cycle as the limit wins: normal completion, no error.
//  MEM_TIMEOUT_EN undefined: REQ waits indefinitely; mem_err tied 0; no counter.
// TESTING
//  1. ALU op: regwrite=1, aluresult=16'h1234, muxout=4'h5, no access
//     -> next cycle wb_alu=16'h1234, wb_dst=5, wb_regwrite=1; exmem_wen stays 1.
//  2. Load: memread=1, aluresult=16'h0040, ack on the 1st REQ cycle with rdata=16'hBEEF
//     -> exmem_wen=0 for 2 cycles, mem_req=1 for 1 cycle;
//        then wb_rdata=16'hBEEF, wb_memtoreg=1.
//  3. Store: memwrite=1, regread2=16'hA5A5, ack after 3 REQ cycles
//     -> mem_we=1, mem_wdata=16'hA5A5 stable for all 3 cycles; 4 stall cycles total.
//  4. Branch: branch=1, zeroflag=1, addresult=16'h0100 -> pc_src=1, branch_target=16'h0100;
//     zeroflag=0 -> pc_src=0.
//  5. Reset asserted in the 2nd REQ cycle of a load -> next cycle mem_req=0,
//     all wb_* outputs 0, state IDLE; a later ack is ignored.
//  6. (MEM_TIMEOUT_EN, TO_CYCLES=4) load with no ack -> mem_err=1 after 4 REQ cycles;
//     wb_regwrite=0; the following ALU op retires normally.

Source files
------------

// File: rtl/mem_stage_ctrl.sv
// ---------------------------------------------------------------------------
// mem_stage_ctrl
// Consumer side of the EX/MEM pipeline register in the 16-bit pipelined CPU.
// Stalls EX/MEM while a data-memory access is in flight. Runs the req/ack
// handshake with data memory. Resolves taken branches. Holds the MEM/WB
// pipeline register that feeds write-back.
//
// Optional feature macro: MEM_TIMEOUT_EN
//   defined   -> an access that sees no ack for TO_CYCLES REQ cycles is
//                abandoned, mem_err is set (sticky), and the instruction
//                retires without a register write.
//   undefined -> REQ waits indefinitely and mem_err is tied low.
//
// Ports
//   clk, rst                 rising-edge clock, synchronous active-low reset
//   regwrite..muxout         EX/MEM fields of the instruction being presented
//   mem_ack, mem_rdata       memory completion and read data (valid with ack)
//   mem_req, mem_we          access request and write select
//   mem_addr, mem_wdata      address (= aluresult) and store data (= regread2)
//   exmem_wen                EX/MEM write enable (0 = hold current instruction)
//   pc_src, branch_target    branch-taken select and target
//   wb_*                     MEM/WB pipeline register outputs
//   mem_err                  sticky access-timeout flag
// ---------------------------------------------------------------------------
module mem_stage_ctrl #(
    parameter int DW        = 16,
    parameter int RW        = 4,
    parameter int TO_CYCLES = 255
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          regwrite,
    input  logic          memtoreg,
    input  logic          branch,
    input  logic          memwrite,
    input  logic          memread,
    input  logic [DW-1:0] addresult,
    input  logic [DW-1:0] aluresult,
    input  logic [DW-1:0] regread2,
    input  logic          zeroflag,
    input  logic [RW-1:0] muxout,
    input  logic          mem_ack,
    input  logic [DW-1:0] mem_rdata,
    output logic          mem_req,
    output logic          mem_we,
    output logic [DW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          exmem_wen,
    output logic          pc_src,
    output logic [DW-1:0] branch_target,
    output logic          wb_regwrite,
    output logic          wb_memtoreg,
    output logic [DW-1:0] wb_rdata,
    output logic [DW-1:0] wb_alu,
    output logic [RW-1:0] wb_dst,
    output logic          mem_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Last REQ cycle index (counter value) before the access is abandoned.
    localparam logic [7:0] TO_LAST = 8'(TO_CYCLES - 1);

    state_t        state_q, state_d;
    logic [DW-1:0] rdbuf_q, rdbuf_d;
    logic          wb_regwrite_q, wb_regwrite_d;
    logic          wb_memtoreg_q, wb_memtoreg_d;
    logic [DW-1:0] wb_rdata_q, wb_rdata_d;
    logic [DW-1:0] wb_alu_q, wb_alu_d;
    logic [RW-1:0] wb_dst_q, wb_dst_d;
    logic          access_s;
    logic          mem_req_s;
    logic          exmem_wen_s;
    logic          timeout_hit_s;
    logic          timed_out_s;

`ifdef MEM_TIMEOUT_EN
    logic [7:0]    to_cnt_q, to_cnt_d;
    logic          timed_out_q, timed_out_d;
    logic          mem_err_q, mem_err_d;

    // Timeout counter, per-access timed-out flag and sticky error flag.
    always_comb begin
        to_cnt_d      = to_cnt_q;
        timed_out_d   = timed_out_q;
        mem_err_d     = mem_err_q;
        timeout_hit_s = 1'b0;
        if (state_q == ST_IDLE && access_s) begin
            to_cnt_d    = 8'd0;
            timed_out_d = 1'b0;
        end else if (state_q == ST_REQ && !mem_ack) begin
            // An ack on the limit cycle takes priority, so only ack-less cycles count.
            if (to_cnt_q == TO_LAST) begin
                timeout_hit_s = 1'b1;
                timed_out_d   = 1'b1;
                mem_err_d     = 1'b1;
            end else begin
                to_cnt_d = to_cnt_q + 8'd1;
            end
        end else begin
            to_cnt_d = to_cnt_q;
        end
    end

    // Timeout state registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            to_cnt_q    <= 8'd0;
            timed_out_q <= 1'b0;
            mem_err_q   <= 1'b0;
        end else begin
            to_cnt_q    <= to_cnt_d;
            timed_out_q <= timed_out_d;
            mem_err_q   <= mem_err_d;
        end
    end

    assign timed_out_s = timed_out_q;
    assign mem_err     = mem_err_q;
`else
    logic unused_to_s;

    assign timeout_hit_s = 1'b0;
    assign timed_out_s   = 1'b0;
    assign mem_err       = 1'b0;
    assign unused_to_s   = ^TO_LAST;
`endif

    assign access_s = memread | memwrite;

    // Next state, handshake outputs and MEM/WB loads.
    always_comb begin
        state_d       = state_q;
        rdbuf_d       = rdbuf_q;
        wb_regwrite_d = wb_regwrite_q;
        wb_memtoreg_d = wb_memtoreg_q;
        wb_rdata_d    = wb_rdata_q;
        wb_alu_d      = wb_alu_q;
        wb_dst_d      = wb_dst_q;
        mem_req_s     = 1'b0;
        exmem_wen_s   = 1'b1;
        case (state_q)
            ST_IDLE: begin
                if (access_s) begin
                    // Hold EX/MEM and push a bubble into write-back.
                    exmem_wen_s   = 1'b0;
                    wb_regwrite_d = 1'b0;
                    wb_memtoreg_d = 1'b0;
                    state_d       = ST_REQ;
                end else begin
                    wb_regwrite_d = regwrite;
                    wb_memtoreg_d = memtoreg;
                    wb_rdata_d    = '0;
                    wb_alu_d      = aluresult;
                    wb_dst_d      = muxout;
                end
            end
            ST_REQ: begin
                mem_req_s   = 1'b1;
                exmem_wen_s = 1'b0;
                if (mem_ack) begin
                    rdbuf_d = mem_rdata;
                    state_d = ST_DONE;
                end else if (timeout_hit_s) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_DONE: begin
                // Retire the held instruction; access is not re-evaluated here.
                wb_regwrite_d = regwrite & ~timed_out_s;
                wb_memtoreg_d = memtoreg;
                wb_rdata_d    = rdbuf_q;
                wb_alu_d      = aluresult;
                wb_dst_d      = muxout;
                state_d       = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, read buffer and MEM/WB pipeline register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            rdbuf_q       <= '0;
            wb_regwrite_q <= 1'b0;
            wb_memtoreg_q <= 1'b0;
            wb_rdata_q    <= '0;
            wb_alu_q      <= '0;
            wb_dst_q      <= '0;
        end else begin
            state_q       <= state_d;
            rdbuf_q       <= rdbuf_d;
            wb_regwrite_q <= wb_regwrite_d;
            wb_memtoreg_q <= wb_memtoreg_d;
            wb_rdata_q    <= wb_rdata_d;
            wb_alu_q      <= wb_alu_d;
            wb_dst_q      <= wb_dst_d;
        end
    end

    assign mem_req       = mem_req_s;
    assign mem_we        = memwrite;
    assign mem_addr      = aluresult;
    assign mem_wdata     = regread2;
    assign exmem_wen     = exmem_wen_s;
    assign pc_src        = branch & zeroflag & (state_q == ST_IDLE);
    assign branch_target = addresult;
    assign wb_regwrite   = wb_regwrite_q;
    assign wb_memtoreg   = wb_memtoreg_q;
    assign wb_rdata      = wb_rdata_q;
    assign wb_alu        = wb_alu_q;
    assign wb_dst        = wb_dst_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Testbench for mem_stage_ctrl: a driver presents one instruction at a time and
// plays the memory side; expected MEM/WB contents go into a scoreboard queue
// and are compared when the DUT commits an instruction (exmem_wen=1 at an edge).
module tb_mem_stage_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        regwrite, memtoreg, branch, memwrite, memread, zeroflag;
    logic [15:0] addresult, aluresult, regread2;
    logic [3:0]  muxout;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic        mem_req, mem_we, exmem_wen, pc_src;
    logic [15:0] mem_addr, mem_wdata, branch_target;
    logic        wb_regwrite, wb_memtoreg;
    logic [15:0] wb_rdata, wb_alu;
    logic [3:0]  wb_dst;
    logic        mem_err;

    typedef struct {
        logic        rw;
        logic        mtr;
        logic [15:0] rdata;
        logic [15:0] alu;
        logic [3:0]  dst;
        logic        chk_rd;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    logic mon_en   = 1'b0;
    logic commit_r = 1'b0;

    always #5 clk = ~clk;

    mem_stage_ctrl #(.DW(16), .RW(4), .TO_CYCLES(4)) dut (
        .clk(clk), .rst(rst),
        .regwrite(regwrite), .memtoreg(memtoreg), .branch(branch),
        .memwrite(memwrite), .memread(memread),
        .addresult(addresult), .aluresult(aluresult), .regread2(regread2),
        .zeroflag(zeroflag), .muxout(muxout),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .exmem_wen(exmem_wen), .pc_src(pc_src),
        .branch_target(branch_target),
        .wb_regwrite(wb_regwrite), .wb_memtoreg(wb_memtoreg),
        .wb_rdata(wb_rdata), .wb_alu(wb_alu), .wb_dst(wb_dst),
        .mem_err(mem_err)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Mid-cycle: will the instruction currently presented commit at the next edge?
    always @(negedge clk) commit_r <= mon_en && exmem_wen && rst;

    // Just after an edge: compare MEM/WB against the oldest expected retirement.
    always @(posedge clk) begin : monitor
        exp_t e;
        #1;
        if (commit_r) begin
            if (sb_q.size() == 0) begin
                check_eq("sb_empty", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                check_eq("wb_regwrite", wb_regwrite, e.rw);
                check_eq("wb_memtoreg", wb_memtoreg, e.mtr);
                check_eq("wb_alu", wb_alu, e.alu);
                check_eq("wb_dst", wb_dst, e.dst);
                if (e.chk_rd) check_eq("wb_rdata", wb_rdata, e.rdata);
            end
        end
    end

    // Present one instruction (called at posedge+2) and answer its memory access
    // with an ack in REQ cycle number ack_at.
    task automatic run_instr(input logic rw, input logic mr, input logic mw, input logic mtr,
                             input logic br, input logic zf, input logic [15:0] alu,
                             input logic [15:0] rd2, input logic [15:0] ares,
                             input logic [3:0] dst, input int ack_at, input logic [15:0] rdata);
        exp_t e;
        int   stalls = 0;
        int   reqs   = 0;
        bit   done   = 1'b0;
        logic acc    = mr | mw;
        regwrite = rw; memread = mr; memwrite = mw; memtoreg = mtr;
        branch = br; zeroflag = zf; aluresult = alu; regread2 = rd2;
        addresult = ares; muxout = dst; mem_ack = 1'b0;
        e.rw = rw; e.mtr = mtr; e.rdata = rdata; e.alu = alu; e.dst = dst; e.chk_rd = acc;
        sb_q.push_back(e);
        for (int cyc = 0; cyc < 40 && !done; cyc++) begin
            #2;
            if (cyc == 0) begin
                check_eq("pc_src", pc_src, br & zf);
                check_eq("branch_target", branch_target, ares);
            end
            if (exmem_wen) begin
                done = 1'b1;
            end else begin
                stalls++;
                if (mem_req) begin
                    reqs++;
                    check_eq("mem_we", mem_we, mw);
                    check_eq("mem_wdata", mem_wdata, rd2);
                    check_eq("mem_addr", mem_addr, alu);
                    check_eq("pc_src_req", pc_src, 1'b0);
                    check_eq("bubble", wb_regwrite, 1'b0);
                    mem_ack   = (reqs == ack_at);
                    mem_rdata = rdata;
                end
            end
            @(posedge clk);
            #2;
            mem_ack = 1'b0;
        end
        if (!done) check_eq("commit_timeout", 32'd0, 32'd1);
        check_eq("stall_cycles", stalls, acc ? ack_at + 1 : 0);
        check_eq("req_cycles", reqs, acc ? ack_at : 0);
    endtask

    initial begin
        rst = 1'b0;
        {regwrite, memtoreg, branch, memwrite, memread, zeroflag} = 6'd0;
        addresult = 16'h0000; aluresult = 16'h0000; regread2 = 16'h0000;
        muxout = 4'h0; mem_ack = 1'b0; mem_rdata = 16'h0000;
        repeat (2) @(posedge clk);
        #2;
        check_eq("rst_wb_regwrite", wb_regwrite, 1'b0);
        check_eq("rst_wb_alu", wb_alu, 16'h0000);
        check_eq("rst_wb_dst", wb_dst, 4'h0);
        check_eq("rst_mem_req", mem_req, 1'b0);
        check_eq("rst_exmem_wen", exmem_wen, 1'b1);
        check_eq("rst_mem_err", mem_err, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #2;
        mon_en = 1'b1;
        // ALU op, load, store, branch taken / not taken, load+store overlap
        run_instr(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h1234, 16'h0000, 16'h0000, 4'h5, 0, 16'h0000);
        run_instr(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0040, 16'h0000, 16'h0000, 4'h3, 1, 16'hBEEF);
        run_instr(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0080, 16'hA5A5, 16'h0000, 4'h0, 3, 16'h0000);
        run_instr(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0000, 16'h0000, 16'h0100, 4'h0, 0, 16'h0000);
        run_instr(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0100, 4'h0, 0, 16'h0000);
        run_instr(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0090, 16'h1111, 16'h0000, 4'h9, 2, 16'h5A5A);
        for (int i = 0; i < 8; i++) begin
            logic m_r, m_w;
            m_r = 1'($urandom_range(0, 1));
            m_w = 1'($urandom_range(0, 1));
            run_instr(1'($urandom_range(0, 1)), m_r, m_w, m_r, 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom), 16'($urandom),
                      4'($urandom), (m_r | m_w) ? int'($urandom_range(1, 3)) : 0, 16'($urandom));
        end
        mon_en = 1'b0;
        check_eq("sb_drain", sb_q.size(), 32'd0);

        // Reset during the second REQ cycle of a load; a late ack must be ignored.
        memread = 1'b1; regwrite = 1'b1; memwrite = 1'b0; aluresult = 16'h0200;
        #2;
        check_eq("r5_idle_wen", exmem_wen, 1'b0);
        @(posedge clk); #2;
        @(posedge clk); #2;
        check_eq("r5_req2", mem_req, 1'b1);
        rst = 1'b0;
        @(posedge clk); #2;
        check_eq("r5_mem_req", mem_req, 1'b0);
        check_eq("r5_wb_regwrite", wb_regwrite, 1'b0);
        check_eq("r5_wb_memtoreg", wb_memtoreg, 1'b0);
        check_eq("r5_wb_rdata", wb_rdata, 16'h0000);
        check_eq("r5_wb_alu", wb_alu, 16'h0000);
        check_eq("r5_wb_dst", wb_dst, 4'h0);
        rst = 1'b1;
        memread = 1'b0; regwrite = 1'b0;
        mem_ack = 1'b1; mem_rdata = 16'hDEAD;
        #2;
        check_eq("r5_late_ack_req", mem_req, 1'b0);
        check_eq("r5_late_ack_wen", exmem_wen, 1'b1);
        @(posedge clk); #2;
        mem_ack = 1'b0;
        check_eq("r5_after_ack_req", mem_req, 1'b0);
        mon_en = 1'b1;
        run_instr(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h4321, 16'h0000, 16'h0000, 4'hA, 0, 16'h0000);
        mon_en = 1'b0;

`ifdef MEM_TIMEOUT_EN
        begin : timeout_test
            int reqs = 0;
            bit done = 1'b0;
            memread = 1'b1; regwrite = 1'b1; memtoreg = 1'b1; muxout = 4'h7;
            for (int cyc = 0; cyc < 40 && !done; cyc++) begin
                #2;
                if (exmem_wen) done = 1'b1;
                else if (mem_req) reqs++;
                @(posedge clk); #2;
            end
            check_eq("to_done", done, 1'b1);
            check_eq("to_req_cycles", reqs, 32'd4);
            check_eq("to_mem_err", mem_err, 1'b1);
            check_eq("to_wb_regwrite", wb_regwrite, 1'b0);
            mon_en = 1'b1;
            run_instr(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h7777, 16'h0000, 16'h0000, 4'h2, 0, 16'h0000);
            mon_en = 1'b0;
            check_eq("to_err_sticky", mem_err, 1'b1);
        end
`else
        check_eq("mem_err_tied", mem_err, 1'b0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
